// File: rtl/logic_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : logic_op_ctrl
// Purpose  : Start/finish sequencer in front of a logic-operation unit.
//            Accepts one request, drives the unit with held operands,
//            waits (bounded) for finish and returns the result or a
//            timeout error on a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module logic_op_ctrl #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   // request port
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   input  logic [2:0]       req_op,
   // response port
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_data,
   output logic             rsp_err,
   // logic unit handshake
   output logic             lu_start,
   output logic [2:0]       lu_op,
   output logic [WIDTH-1:0] lu_a,
   output logic [WIDTH-1:0] lu_b,
   input  logic             lu_finish,
   input  logic [WIDTH-1:0] lu_c,
   // status
   output logic             busy
);

   // Wait counter is just wide enough to hold TIMEOUT.
   localparam int              c_cnt_w   = $clog2(TIMEOUT + 1);
   localparam logic [c_cnt_w-1:0] c_limit   = c_cnt_w'(TIMEOUT - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_max = {c_cnt_w{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t              state_q;
   logic [c_cnt_w-1:0]  cnt_q;
   logic                req_ready_q;
   logic                rsp_valid_q;
   logic [WIDTH-1:0]    rsp_data_q;
   logic                rsp_err_q;
   logic                lu_start_q;
   logic [2:0]          lu_op_q;
   logic [WIDTH-1:0]    lu_a_q;
   logic [WIDTH-1:0]    lu_b_q;
   logic                busy_q;

   // Sequencer: every output is a register so the unit and the consumer
   // never see combinational paths from our inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         lu_start_q  <= 1'b0;
         lu_op_q     <= '0;
         lu_a_q      <= '0;
         lu_b_q      <= '0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Operands are captured once here and held until the next
               // accepted request, so the unit sees stable inputs.
               if (req_valid && req_ready_q) begin
                  lu_a_q      <= req_a;
                  lu_b_q      <= req_b;
                  lu_op_q     <= req_op;
                  lu_start_q  <= 1'b1;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  state_q     <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               // Start is a single-cycle pulse; finish is not looked at yet
               // because the unit requires start to drop first.
               lu_start_q <= 1'b0;
               cnt_q      <= '0;
               state_q    <= ST_WAIT;
            end
            ST_WAIT: begin
               // Finish takes priority over the limit check, so a finish on
               // the last allowed cycle is still a good result.
               if (lu_finish) begin
                  rsp_data_q  <= lu_c;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (cnt_q == c_limit) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  state_q     <= ST_RESP;
               end else if (cnt_q != c_cnt_max) begin
                  cnt_q <= cnt_q + c_cnt_w'(1);
               end
            end
            ST_RESP: begin
               // Data/err are untouched here, which keeps them stable under
               // backpressure and immune to stray finish pulses.
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign lu_start  = lu_start_q;
   assign lu_op     = lu_op_q;
   assign lu_a      = lu_a_q;
   assign lu_b      = lu_b_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_op_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_op_ctrl
// Purpose  : Self-checking bench for logic_op_ctrl: stimulus pushes expected
//            responses into a scoreboard, a monitor pops and compares them,
//            and a behavioural logic-unit model answers start pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_op_ctrl;

   localparam int WIDTH   = 32;
   localparam int TIMEOUT = 15;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_valid;
   logic             req_ready;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic [2:0]       req_op;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_data;
   logic             rsp_err;
   logic             lu_start;
   logic [2:0]       lu_op;
   logic [WIDTH-1:0] lu_a;
   logic [WIDTH-1:0] lu_b;
   logic             lu_finish;
   logic [WIDTH-1:0] lu_c;
   logic             busy;

   logic_op_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .lu_start  (lu_start),
      .lu_op     (lu_op),
      .lu_a      (lu_a),
      .lu_b      (lu_b),
      .lu_finish (lu_finish),
      .lu_c      (lu_c),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          acc;   // cycle count at the accepting edge
      int          lat;   // edges from accept to first rsp_valid
   } exp_t;

   typedef struct {
      int          delay; // WAIT cycle in which finish is given, 0 = never
      bit          ovr;
      logic [31:0] ovr_val;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
   } cfg_t;

   exp_t        exp_q[$];
   cfg_t        cfg_q[$];
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          spur_en = 1'b0;
   int          spur_req = 0;
   int          bp_len = 0;
   bit          bp_rand = 1'b0;
   logic [31:0] last_exp_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Operation table of the logic unit.
   function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      case (op)
         3'd0:    return ~a;
         3'd1:    return ~b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~(a & b);
         3'd6:    return ~(a | b);
         default: return ~(a ^ b);
      endcase
   endfunction

   // Logic unit model: answers each start after the configured number of
   // WAIT cycles, and fires stray finish pulses while not in a transaction.
   initial begin : lu_model
      cfg_t cur;
      bit   active;
      int   wcnt;
      int   spur_done;
      active    = 1'b0;
      wcnt      = 0;
      spur_done = 0;
      lu_finish = 1'b0;
      lu_c      = '0;
      forever begin
         @(negedge clk);
         #1;
         lu_finish = 1'b0;
         lu_c      = $urandom;
         if (rst) begin
            active = 1'b0;
         end else if (lu_start) begin
            chk("lu_start_single_pulse", 64'(active), 64'(0));
            if (cfg_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL lu_start_unexpected: got start with no request pending (cycle %0d)", cyc);
               active = 1'b0;
            end else begin
               cur    = cfg_q.pop_front();
               active = 1'b1;
               wcnt   = 0;
               chk("lu_a_issue", 64'(lu_a), 64'(cur.a));
               chk("lu_b_issue", 64'(lu_b), 64'(cur.b));
               chk("lu_op_issue", 64'(lu_op), 64'(cur.op));
            end
         end else if (active) begin
            wcnt++;
            chk("lu_a_hold", 64'(lu_a), 64'(cur.a));
            chk("lu_op_hold", 64'(lu_op), 64'(cur.op));
            if (cur.delay == wcnt) begin
               lu_finish = 1'b1;
               lu_c      = cur.ovr ? cur.ovr_val : ref_op(lu_op, lu_a, lu_b);
               active    = 1'b0;
            end else if (wcnt >= TIMEOUT) begin
               active = 1'b0;
            end
         end else if (spur_req != spur_done || (spur_en && $urandom_range(0, 2) == 0)) begin
            spur_done = spur_req;
            lu_finish = 1'b1;
         end
      end
   end

   // Response consumer: always ready, random, or a fixed number of stalls.
   initial begin : consumer
      int seen;
      seen      = 0;
      rsp_ready = 1'b1;
      forever begin
         @(negedge clk);
         #1;
         if (rsp_valid) begin
            if (bp_len > 0)   rsp_ready = (seen >= bp_len);
            else if (bp_rand) rsp_ready = ($urandom_range(0, 3) != 0);
            else              rsp_ready = 1'b1;
            seen++;
         end else begin
            seen      = 0;
            rsp_ready = bp_rand ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end
   end

   // Monitor: compares every presented response against the scoreboard head.
   initial begin : monitor
      bit prev_valid;
      bit after_hs;
      prev_valid = 1'b0;
      after_hs   = 1'b0;
      forever begin
         @(negedge clk);
         #2;
         if (after_hs) begin
            chk("idle_after_rsp_req_ready", 64'(req_ready), 64'(1));
            chk("idle_after_rsp_busy", 64'(busy), 64'(0));
            after_hs = 1'b0;
         end
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected: got rsp_valid with data 0x%0h, none pending (cycle %0d)",
                        rsp_data, cyc);
            end else begin
               if (!prev_valid)
                  chk("rsp_latency", 64'(cyc - exp_q[0].acc), 64'(exp_q[0].lat));
               chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
               chk("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
               chk("req_ready_in_resp", 64'(req_ready), 64'(0));
               chk("busy_in_resp", 64'(busy), 64'(1));
               if (rsp_ready) begin
                  last_exp_data = exp_q[0].data;
                  void'(exp_q.pop_front());
                  after_hs = 1'b1;
               end
            end
         end
         prev_valid = rsp_valid;
      end
   end

   // Issue one request; returns after the accepting edge with req_valid high.
   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       input int delay, input bit ovr, input logic [31:0] ovr_val,
                       input logic [31:0] exp_data);
      cfg_t c;
      exp_t e;
      int   w;
      @(negedge clk);
      req_a     = a;
      req_b     = b;
      req_op    = op;
      req_valid = 1'b1;
      w = 0;
      while (!req_ready && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_accept_timeout: req_ready stayed 0 for %0d cycles, expected 1", w);
         req_valid = 1'b0;
         return;
      end
      if (delay >= 1 && delay <= TIMEOUT) begin
         e.data = exp_data;
         e.err  = 1'b0;
         e.lat  = 1 + delay;
      end else begin
         e.data = '0;
         e.err  = 1'b1;
         e.lat  = 1 + TIMEOUT;
      end
      e.acc     = cyc + 1;
      c.delay   = delay;
      c.ovr     = ovr;
      c.ovr_val = ovr_val;
      c.a       = a;
      c.b       = b;
      c.op      = op;
      exp_q.push_back(e);
      cfg_q.push_back(c);
      @(posedge clk);
   endtask

   task automatic drop_valid();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'(1));
      chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
      chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(0));
      chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
      chk({tag, "_lu_start"}, 64'(lu_start), 64'(0));
      chk({tag, "_lu_op"}, 64'(lu_op), 64'(0));
      chk({tag, "_lu_a"}, 64'(lu_a), 64'(0));
      chk({tag, "_lu_b"}, 64'(lu_b), 64'(0));
      chk({tag, "_busy"}, 64'(busy), 64'(0));
   endtask

   initial begin : watchdog
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [31:0] ra;
      logic [31:0] rb;
      logic [2:0]  rop;
      int          d;
      int          r;
      logic [31:0] tbl [8];
      tbl[0] = 32'h5555_AAAA; tbl[1] = 32'hCCCC_3333;
      tbl[2] = 32'h2222_4444; tbl[3] = 32'hBBBB_DDDD;
      tbl[4] = 32'h9999_9999; tbl[5] = 32'hDDDD_BBBB;
      tbl[6] = 32'h4444_2222; tbl[7] = 32'h6666_6666;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_op    = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_reset_state("reset");

      // Basic AND, finish in first WAIT cycle.
      send(32'hF0F0_1234, 32'h0FF0_FFFF, 3'd2, 1, 1'b0, '0, 32'h00F0_1234);
      drop_valid();
      drain();

      // Backpressure: NOTA of zero held for 5 stalled cycles.
      bp_len = 5;
      send(32'h0000_0000, 32'h0000_0000, 3'd0, 1, 1'b0, '0, 32'hFFFF_FFFF);
      drop_valid();
      drain();
      bp_len = 0;

      // Timeout: the unit never finishes.
      send(32'h1234_5678, 32'h9ABC_DEF0, 3'd4, 0, 1'b0, '0, '0);
      drop_valid();
      drain();

      // Finish arrives on the last allowed WAIT cycle.
      send(32'h1111_2222, 32'h3333_4444, 3'd3, TIMEOUT, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
      drop_valid();
      drain();

      // Reset while waiting: no response, then a normal request.
      send(32'hCAFE_F00D, 32'h0BAD_BEEF, 3'd5, 0, 1'b0, '0, '0);
      drop_valid();
      repeat (4) @(negedge clk);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      check_reset_state("midop_reset");
      repeat (3) @(negedge clk);
      chk("midop_reset_no_rsp", 64'(rsp_valid), 64'(0));
      send(32'h0F0F_0F0F, 32'h00FF_00FF, 3'd6, 2, 1'b0, '0, 32'hF000_F000);
      drop_valid();
      drain();

      // Stray finish while idle, then 8 back-to-back requests.
      spur_req++;
      @(negedge clk);
      @(negedge clk);
      chk("spurious_idle_busy", 64'(busy), 64'(0));
      chk("spurious_idle_rsp_valid", 64'(rsp_valid), 64'(0));
      chk("spurious_idle_rsp_data", 64'(rsp_data), 64'(last_exp_data));
      for (int i = 0; i < 8; i++)
         send(32'hAAAA_5555, 32'h3333_CCCC, 3'(i), 1, 1'b0, '0, tbl[i]);
      drop_valid();
      drain();

      // Randomized traffic with stray finishes and random backpressure.
      spur_en = 1'b1;
      bp_rand = 1'b1;
      for (int n = 0; n < 40; n++) begin
         ra  = $urandom;
         rb  = $urandom;
         rop = 3'($urandom_range(0, 7));
         r   = int'($urandom_range(0, 9));
         if (r == 0)      d = 0;
         else if (r == 1) d = TIMEOUT;
         else if (r == 2) d = int'($urandom_range(1, TIMEOUT));
         else             d = int'($urandom_range(1, 4));
         send(ra, rb, rop, d, 1'b0, '0, ref_op(rop, ra, rb));
         if ($urandom_range(0, 1) == 0) drop_valid();
      end
      drop_valid();
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/logic_op_ctrl.md
Name: logic_op_ctrl

Overview:
- Sequencer that sits directly upstream of the logic-operation unit and owns its start/finish protocol.
- Accepts one logic request (A, B, 3-bit op) on a valid/ready port and holds operands stable.
- Pulses start, waits for finish, captures the result and returns it on a valid/ready response port.
- Flags a timeout when finish never arrives, so the ALU datapath cannot hang.

Parameters:
- WIDTH, 32, operand/result width.
- TIMEOUT, 15, maximum WAIT cycles before the error response; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_op  in  3  opcode: 0 NOTA, 1 NOTB, 2 AND, 3 OR, 4 XOR, 5 NAND, 6 NOR, 7 XNOR.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  result.
- rsp_err  out  1  timeout indicator, qualified by rsp_valid.
- lu_start  out  1  start to the logic unit.
- lu_op  out  3  opcode to the logic unit.
- lu_a  out  WIDTH  operand A to the logic unit.
- lu_b  out  WIDTH  operand B to the logic unit.
- lu_finish  in  1  finish from the logic unit.
- lu_c  in  WIDTH  result from the logic unit.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_data=0; lu_start=0; lu_op=0; lu_a=0; lu_b=0; busy=0; wait counter=0.
- Reset mid-operation aborts immediately. No response is produced for the aborted request.
- FSM states are IDLE, ISSUE, WAIT and RESP. All outputs are registered.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, register req_a/req_b/req_op into lu_a/lu_b/lu_op and go to ISSUE.
  - Without req_valid, stay in IDLE.
- ISSUE:
  - lu_start=1 for exactly this one cycle.
  - Clear the counter; next state WAIT.
  - lu_finish is ignored in this state.
- WAIT:
  - lu_start=0, which satisfies the logic unit's "start low then finish" sequence.
  - lu_a/lu_b/lu_op stay held unchanged.
  - If lu_finish=1: capture lu_c into rsp_data, set rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: set rsp_data=0 and rsp_err=1, go to RESP.
  - Else increment the counter.
  - If finish arrives in the same cycle as the timeout limit, finish wins and there is no error.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the rsp_valid&rsp_ready cycle, the next state is IDLE and rsp_valid drops on the following edge.
- lu_finish outside WAIT is ignored and must not corrupt rsp_data.
- req_ready=0 outside IDLE; one transaction is in flight at most.
- Latency with a logic unit that finishes in the first WAIT cycle:
  - request accepted at edge 0;
  - lu_start=1 during cycle 1;
  - finish sampled in cycle 2;
  - rsp_valid=1 from cycle 3.
  - Minimum 4-cycle issue interval, given rsp_ready=1.
- Counter width is ceil(log2(TIMEOUT+1)). The counter saturates and never wraps.
- Opcode is passed through unmodified. All 3-bit values are legal; there is no decode error.

Test Plan:
- Basic AND: reset, then request a=0xF0F0_1234, b=0x0FF0_FFFF, op=2, rsp_ready=1, with the unit model returning A&B.
  -> lu_start high for 1 cycle; rsp_valid in cycle 3; rsp_data=0x00F0_1234; rsp_err=0.
- Backpressure: same NOTA request (a=0x0000_0000), rsp_ready=0 for 5 cycles.
  -> rsp_valid stays 1 and rsp_data stays 0xFFFF_FFFF; req_ready=0 throughout; IDLE one cycle after rsp_ready=1.
- Timeout: TIMEOUT=15, model never asserts lu_finish.
  -> exactly 15 WAIT cycles; then rsp_valid=1, rsp_err=1, rsp_data=0.
- Finish on limit: model asserts lu_finish in the 15th WAIT cycle with lu_c=0xDEAD_BEEF.
  -> rsp_err=0, rsp_data=0xDEAD_BEEF.
- Reset mid-op: assert rst for one cycle while in WAIT.
  -> next cycle IDLE; all outputs at reset values; no rsp_valid; a subsequent request completes normally.
- Back-to-back with spurious finish: req_valid held high with 8 requests covering op 0..7 (a=0xAAAA_5555, b=0x3333_CCCC); lu_finish pulsed while in IDLE.
  -> spurious pulse ignored; 8 responses in order matching each op.
  -> Expected results: NOTA 0x5555_AAAA, NOTB 0xCCCC_3333, AND 0x2222_4444, OR 0xBBBB_DDDD, XOR 0x9999_9999, NAND 0xDDDD_BBBB, NOR 0x4444_2222, XNOR 0x6666_6666.
